prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Upstream control stage for the 9-bit core; owns the bench handshake (req/ack) across a batch of programs.
- On each bench request it selects the next program's start address and holds the core in init for a fixed number of cycles.
- It then releases the core and watches for halt; when halt is seen it returns ack with a per-program cycle count.
- It feeds the fetch stage's init input and start target, and consumes the core's halt indication.

Parameters:
- A, 16, instruction address width (matches InstROM).
- NPROG, 3, number of programs in the batch (1..8).
- INIT_CYCLES, 2, cycles core_init is held high per launch (>=1).
- TIMEOUT, 16'hFFFF, run-cycle limit before forced completion.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high master reset
- req  in  1  bench request; a rising edge starts the next program
- core_halt  in  1  core has reached the halt address (PC == all-ones)
- core_init  out  1  held high to reset the fetch PC to start_pc
- start_pc  out  A  start address of the current program
- prog_idx  out  3  index of the current/last program, 0..NPROG-1
- ack  out  1  done with the current program, bench may sample results
- busy  out  1  high in LAUNCH or RUN
- cycle_count  out  16  run cycles of the current/last program, saturating
- timeout  out  1  last program ended by TIMEOUT, not by halt

Behaviour:
- Reset is synchronous and active-high; it wins over all other inputs, including mid-run. Reset values:
  - state=IDLE, core_init=0, ack=0, busy=0, timeout=0
  - cycle_count=0, prog_idx=0, start_pc=PROG_START[0], req_q=0
- req_q is a registered copy of req; req_rise = req & ~req_q. Only req_rise launches. A level-held req does not relaunch.
- IDLE:
  - On req_rise go to LAUNCH.
  - Load start_pc=PROG_START[prog_idx]; clear cycle_count and timeout.
- LAUNCH:
  - core_init=1 and busy=1 for exactly INIT_CYCLES cycles (init counter, 3 bits min).
  - core_halt is ignored here, because the PC may still read all-ones.
  - After the last init cycle go to RUN.
- RUN:
  - core_init=0, busy=1.
  - cycle_count increments each cycle, including the cycle halt is seen; it saturates at 16'hFFFF.
  - If core_halt=1, go to DONE.
  - Else if cycle_count==TIMEOUT-1 this cycle, go to DONE with timeout=1.
- DONE:
  - ack=1, busy=0; cycle_count and timeout are held.
  - On req_rise: clear ack, advance prog_idx (NPROG-1 wraps to 0), reload start_pc, go to LAUNCH.
- Timing:
  - ack rises 1 cycle after the cycle core_halt is sampled high in RUN.
  - core_init rises 1 cycle after req_rise.
- req_rise while busy is ignored; no queuing.
- All outputs are registered; there are no combinational input-to-output paths.
- start_pc is stable from LAUNCH entry until the next launch.

Decomposition:
- Shared package seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} seq_state_t
  - localparam PROG_START[0:7] (A-bit start addresses; default 0, 'h40, 'h80)
  - HALT_PC = all-ones
- One natural sub-module: sat_counter (16-bit, clear, enable, saturate), used for cycle_count.
- The FSM stays inline.

Test Plan:
- Reset then req pulse -> core_init high exactly 2 cycles starting 1 cycle after req_rise; start_pc=0, prog_idx=0, busy=1.
- Core_halt asserted 10 cycles after RUN entry -> ack=1 next cycle, cycle_count=11, timeout=0, busy=0.
- Three req/halt rounds then a fourth req -> prog_idx sequence 0,1,2,0; start_pc sequence 0,'h40,'h80,0.
- TIMEOUT=20, core_halt never asserted -> DONE after 20 RUN cycles, ack=1, timeout=1, cycle_count=20.
- core_halt held high through LAUNCH -> ignored; DONE reached at RUN cycle 1, cycle_count=1. req held high across DONE -> no relaunch.
- reset asserted mid-RUN (cycle_count=5) -> next cycle IDLE, ack=0, core_init=0, cycle_count=0, prog_idx=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states, per-program start
// addresses and the core's halt address.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} seq_state_t;

  localparam logic [15:0] PROG_START [0:7] = '{
    16'h0000, 16'h0040, 16'h0080, 16'h00C0,
    16'h0100, 16'h0140, 16'h0180, 16'h01C0
  };

  localparam logic [15:0] HALT_PC = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Launches a batch of programs on the core one bench request at a time: holds the core in
// init, releases it, waits for halt or timeout and reports a per-program run-cycle count.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned A           = 16,
  parameter int unsigned NPROG       = 3,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         core_halt,
  output logic         core_init,
  output logic [A-1:0] start_pc,
  output logic [2:0]   prog_idx,
  output logic         ack,
  output logic         busy,
  output logic [15:0]  cycle_count,
  output logic         timeout
);

  localparam int unsigned InitW = (INIT_CYCLES > 7) ? $clog2(INIT_CYCLES) : 3;

  seq_state_t       state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic             req_q;
  logic             core_init_q, core_init_d;
  logic [A-1:0]     start_pc_q, start_pc_d;
  logic [2:0]       prog_idx_q, prog_idx_d;
  logic [2:0]       next_idx;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_en;
  logic             req_rise;

  assign req_rise = req & ~req_q;
  assign next_idx = (prog_idx_q == 3'(NPROG - 1)) ? 3'd0 : prog_idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    core_init_d = core_init_q;
    start_pc_d  = start_pc_q;
    prog_idx_d  = prog_idx_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d     = LAUNCH;
          start_pc_d  = A'(PROG_START[prog_idx_q]);
          init_cnt_d  = '0;
          core_init_d = 1'b1;
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      LAUNCH: begin
        // Halt is not looked at here: the PC may still read all-ones until init takes hold.
        if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
          state_d     = RUN;
          core_init_d = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (core_halt) begin
          state_d = DONE;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (cycle_count == 16'(TIMEOUT - 1)) begin
          state_d   = DONE;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (req_rise) begin
          state_d     = LAUNCH;
          ack_d       = 1'b0;
          prog_idx_d  = next_idx;
          start_pc_d  = A'(PROG_START[next_idx]);
          init_cnt_d  = '0;
          core_init_d = 1'b1;
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      req_q       <= 1'b0;
      core_init_q <= 1'b0;
      start_pc_q  <= A'(PROG_START[0]);
      prog_idx_q  <= 3'd0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      req_q       <= req;
      core_init_q <= core_init_d;
      start_pc_q  <= start_pc_d;
      prog_idx_q  <= prog_idx_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  sat_counter #(
    .Width (16)
  ) u_cycle_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycle_count)
  );

  assign core_init = core_init_q;
  assign start_pc  = start_pc_q;
  assign prog_idx  = prog_idx_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: launch timing, halt and timeout completion, program
// rotation, level-held req, and mid-run reset.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        core_halt;
  logic        core_init;
  logic [15:0] start_pc;
  logic [2:0]  prog_idx;
  logic        ack;
  logic        busy;
  logic [15:0] cycle_count;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  prog_sequencer #(
    .A           (16),
    .NPROG       (3),
    .INIT_CYCLES (2),
    .TIMEOUT     (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .core_halt   (core_halt),
    .core_init   (core_init),
    .start_pc    (start_pc),
    .prog_idx    (prog_idx),
    .ack         (ack),
    .busy        (busy),
    .cycle_count (cycle_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assumes req is low and has been sampled low; leaves req high and the FSM in RUN.
  task automatic launch(input logic [2:0] exp_idx, input logic [15:0] exp_pc);
    req = 1'b1;
    step();
    check("launch_init1", core_init, 1);
    check("launch_busy", busy, 1);
    check("launch_ack", ack, 0);
    check("launch_idx", prog_idx, exp_idx);
    check("launch_pc", start_pc, exp_pc);
    check("launch_cnt", cycle_count, 0);
    check("launch_tmo", timeout, 0);
    step();
    check("launch_init2", core_init, 1);
    step();
    check("run_init_low", core_init, 0);
    check("run_busy", busy, 1);
    check("run_ack", ack, 0);
  endtask

  task automatic check_done(input logic [15:0] exp_cnt, input logic exp_tmo);
    check("done_ack", ack, 1);
    check("done_busy", busy, 0);
    check("done_cnt", cycle_count, exp_cnt);
    check("done_tmo", timeout, exp_tmo);
  endtask

  initial begin
    reset     = 1'b1;
    req       = 1'b0;
    core_halt = 1'b0;
    steps(2);
    reset = 1'b0;
    check("rst_init", core_init, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout, 0);
    check("rst_cnt", cycle_count, 0);
    check("rst_idx", prog_idx, 0);
    check("rst_pc", start_pc, 16'h0000);
    step();
    check("idle_init", core_init, 0);

    // Program 0: halt ten cycles after RUN entry.
    launch(3'd0, 16'h0000);
    req = 1'b0;
    steps(10);
    check("p0_cnt10", cycle_count, 10);
    check("p0_ack_pre", ack, 0);
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    check_done(16'd11, 1'b0);
    steps(2);
    check("p0_hold_cnt", cycle_count, 11);
    check("p0_hold_ack", ack, 1);

    // Program 1: a req pulse while running is ignored.
    launch(3'd1, 16'h0040);
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    check("busy_req_idx", prog_idx, 1);
    check("busy_req_init", core_init, 0);
    req = 1'b0;
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    check_done(16'd3, 1'b0);

    // Program 2: no halt, forced completion after 20 RUN cycles.
    step();
    launch(3'd2, 16'h0080);
    req = 1'b0;
    steps(19);
    check("tmo_cnt19", cycle_count, 19);
    check("tmo_ack_pre", ack, 0);
    step();
    check_done(16'd20, 1'b1);

    // Wrap to program 0 with halt held through LAUNCH and req held through DONE.
    core_halt = 1'b1;
    launch(3'd0, 16'h0000);
    step();
    check_done(16'd1, 1'b0);
    core_halt = 1'b0;
    steps(3);
    check("held_req_ack", ack, 1);
    check("held_req_init", core_init, 0);
    check("held_req_idx", prog_idx, 0);
    check("held_req_busy", busy, 0);

    // Reset in the middle of a run.
    req = 1'b0;
    step();
    launch(3'd1, 16'h0040);
    req = 1'b0;
    steps(5);
    check("mid_cnt5", cycle_count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_ack", ack, 0);
    check("mrst_init", core_init, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cnt", cycle_count, 0);
    check("mrst_idx", prog_idx, 0);
    check("mrst_pc", start_pc, 16'h0000);

    // Relaunch after reset starts again from program 0.
    step();
    launch(3'd0, 16'h0000);
    req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
